// File: rtl/vdma_axi4s_to_axi4_core.sv
// Write-side video DMA core: takes an AXI4-Stream video frame and writes it
// to memory through an AXI4 write master (AW/W/B), one line at a time with a
// programmable stride.
//
// Ports:
//   aclk_i, aresetn_i        clock, asynchronous active-low reset
//   enable_i / busy_o        start a frame when idle / frame in progress
//   param_*_i                frame base (bytes), stride (words), width (words),
//                            height (lines), burst length-1
//   status_*_o               frame acceptance index and latched shadow params
//   m_axi4_aw*/w*/b*         AXI4 write master channels
//   s_axi4s_*                AXI4-Stream video input (tuser[0] = frame start)
module vdma_axi4s_to_axi4_core #(
    parameter int unsigned AXI4_ID_WIDTH     = 6,
    parameter int unsigned AXI4_ADDR_WIDTH   = 32,
    parameter int unsigned AXI4_LEN_WIDTH    = 8,
    parameter int unsigned AXI4_QOS_WIDTH    = 4,
    parameter int unsigned AXI4S_USER_WIDTH  = 1,
    parameter int unsigned AXI4S_DATA_WIDTH  = 24,
    parameter int unsigned STRIDE_WIDTH      = 12,
    parameter int unsigned INDEX_WIDTH       = 8,
    parameter int unsigned H_WIDTH           = 12,
    parameter int unsigned V_WIDTH           = 12,
    parameter int unsigned OUTSTANDING_WIDTH = 6
) (
    input  logic                        aresetn_i,
    input  logic                        aclk_i,
    input  logic                        enable_i,
    output logic                        busy_o,

    input  logic [AXI4_ADDR_WIDTH-1:0]  param_addr_i,
    input  logic [STRIDE_WIDTH-1:0]     param_stride_i,
    input  logic [H_WIDTH-1:0]          param_width_i,
    input  logic [V_WIDTH-1:0]          param_height_i,
    input  logic [AXI4_LEN_WIDTH-1:0]   param_awlen_i,

    output logic [INDEX_WIDTH-1:0]      status_index_o,
    output logic [AXI4_ADDR_WIDTH-1:0]  status_addr_o,
    output logic [STRIDE_WIDTH-1:0]     status_stride_o,
    output logic [H_WIDTH-1:0]          status_width_o,
    output logic [V_WIDTH-1:0]          status_height_o,
    output logic [AXI4_LEN_WIDTH-1:0]   status_awlen_o,

    output logic [AXI4_ID_WIDTH-1:0]    m_axi4_awid_o,
    output logic [AXI4_ADDR_WIDTH-1:0]  m_axi4_awaddr_o,
    output logic [1:0]                  m_axi4_awburst_o,
    output logic [3:0]                  m_axi4_awcache_o,
    output logic [AXI4_LEN_WIDTH-1:0]   m_axi4_awlen_o,
    output logic                        m_axi4_awlock_o,
    output logic [2:0]                  m_axi4_awprot_o,
    output logic [AXI4_QOS_WIDTH-1:0]   m_axi4_awqos_o,
    output logic [3:0]                  m_axi4_awregion_o,
    output logic [2:0]                  m_axi4_awsize_o,
    output logic                        m_axi4_awvalid_o,
    input  logic                        m_axi4_awready_i,

    output logic [31:0]                 m_axi4_wdata_o,
    output logic [3:0]                  m_axi4_wstrb_o,
    output logic                        m_axi4_wlast_o,
    output logic                        m_axi4_wvalid_o,
    input  logic                        m_axi4_wready_i,

    input  logic [AXI4_ID_WIDTH-1:0]    m_axi4_bid_i,
    input  logic [1:0]                  m_axi4_bresp_i,
    input  logic                        m_axi4_bvalid_i,
    output logic                        m_axi4_bready_o,

    input  logic [AXI4S_USER_WIDTH-1:0] s_axi4s_tuser_i,
    input  logic                        s_axi4s_tlast_i,
    input  logic [AXI4S_DATA_WIDTH-1:0] s_axi4s_tdata_i,
    input  logic                        s_axi4s_tvalid_i,
    output logic                        s_axi4s_tready_o
);

    typedef enum logic [1:0] {AwIdle, AwRun, AwDone} aw_state_e;
    typedef enum logic [1:0] {WIdle, WWaitFs, WData, WDone} w_state_e;

    localparam logic [OUTSTANDING_WIDTH-1:0] OutstMax = {OUTSTANDING_WIDTH{1'b1}};

    logic                        busy_q, busy_d;
    logic [INDEX_WIDTH-1:0]      index_q, index_d;
    logic [AXI4_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [STRIDE_WIDTH-1:0]     stride_q, stride_d;
    logic [H_WIDTH-1:0]          width_q, width_d;
    logic [V_WIDTH-1:0]          height_q, height_d;
    logic [AXI4_LEN_WIDTH-1:0]   awlen_q, awlen_d;

    aw_state_e                   aw_state_q, aw_state_d;
    logic [AXI4_ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [AXI4_ADDR_WIDTH-1:0]  line_base_q, line_base_d;
    logic [H_WIDTH-1:0]          aw_h_q, aw_h_d;
    logic [V_WIDTH-1:0]          aw_v_q, aw_v_d;

    w_state_e                    w_state_q, w_state_d;
    logic [AXI4_LEN_WIDTH-1:0]   beat_q, beat_d;
    logic [H_WIDTH-1:0]          w_h_q, w_h_d;
    logic [V_WIDTH-1:0]          w_v_q, w_v_d;

    logic [OUTSTANDING_WIDTH-1:0] outst_q, outst_d;

    logic                        aw_hs, w_hs, b_hs, done_all;
    logic [H_WIDTH-1:0]          burst_words, aw_h_next, w_h_next;
    logic [AXI4_ADDR_WIDTH-1:0]  burst_bytes, stride_bytes, next_line_base;

    // Response id/resp, tlast and upper tuser bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi4_bid_i, m_axi4_bresp_i, s_axi4s_tlast_i, s_axi4s_tuser_i};

    // Fixed AW payload fields and W strobes.
    assign m_axi4_awid_o     = '0;
    assign m_axi4_awburst_o  = 2'b01;
    assign m_axi4_awcache_o  = 4'b0011;
    assign m_axi4_awlock_o   = 1'b0;
    assign m_axi4_awprot_o   = 3'b000;
    assign m_axi4_awqos_o    = '0;
    assign m_axi4_awregion_o = 4'b0000;
    assign m_axi4_awsize_o   = 3'b010;
    assign m_axi4_awlen_o    = awlen_q;
    assign m_axi4_awaddr_o   = awaddr_q;
    assign m_axi4_wstrb_o    = 4'b1111;
    assign m_axi4_wdata_o    = 32'(s_axi4s_tdata_i);
    assign m_axi4_bready_o   = 1'b1;

    assign busy_o          = busy_q;
    assign status_index_o  = index_q;
    assign status_addr_o   = addr_q;
    assign status_stride_o = stride_q;
    assign status_width_o  = width_q;
    assign status_height_o = height_q;
    assign status_awlen_o  = awlen_q;

    // AW only waits on the outstanding limit; the count cannot rise without an
    // AW handshake, so awvalid never drops before it is accepted.
    assign m_axi4_awvalid_o = (aw_state_q == AwRun) && (outst_q != OutstMax);

    // W is a direct pass-through of the stream; no data is buffered.
    assign m_axi4_wvalid_o = (w_state_q == WData) && s_axi4s_tvalid_i;
    assign m_axi4_wlast_o  = (w_state_q == WData) && (beat_q == awlen_q);

    always_comb begin
        s_axi4s_tready_o = 1'b0;
        unique case (w_state_q)
            WWaitFs: s_axi4s_tready_o = !s_axi4s_tuser_i[0];  // drop pre-frame beats
            WData:   s_axi4s_tready_o = m_axi4_wready_i;
            WIdle, WDone: s_axi4s_tready_o = 1'b0;
        endcase
    end

    assign aw_hs = m_axi4_awvalid_o & m_axi4_awready_i;
    assign w_hs  = m_axi4_wvalid_o & m_axi4_wready_i;
    assign b_hs  = m_axi4_bvalid_i & m_axi4_bready_o;

    assign burst_words    = H_WIDTH'(awlen_q) + H_WIDTH'(1);
    assign burst_bytes    = (AXI4_ADDR_WIDTH'(awlen_q) + AXI4_ADDR_WIDTH'(1)) << 2;
    assign stride_bytes   = AXI4_ADDR_WIDTH'(stride_q) << 2;
    assign next_line_base = line_base_q + stride_bytes;
    assign aw_h_next      = aw_h_q + burst_words;
    assign w_h_next       = w_h_q + H_WIDTH'(1);

    assign done_all = (aw_state_q == AwDone) && (w_state_q == WDone) && (outst_q == '0);

    always_comb begin
        busy_d      = busy_q;
        index_d     = index_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        width_d     = width_q;
        height_d    = height_q;
        awlen_d     = awlen_q;
        aw_state_d  = aw_state_q;
        awaddr_d    = awaddr_q;
        line_base_d = line_base_q;
        aw_h_d      = aw_h_q;
        aw_v_d      = aw_v_q;
        w_state_d   = w_state_q;
        beat_d      = beat_q;
        w_h_d       = w_h_q;
        w_v_d       = w_v_q;
        outst_d     = outst_q;

        if (!busy_q) begin
            if (enable_i) begin
                busy_d      = 1'b1;
                index_d     = index_q + INDEX_WIDTH'(1);
                addr_d      = param_addr_i;
                stride_d    = param_stride_i;
                width_d     = param_width_i;
                height_d    = param_height_i;
                awlen_d     = param_awlen_i;
                aw_state_d  = AwRun;
                awaddr_d    = param_addr_i;
                line_base_d = param_addr_i;
                aw_h_d      = '0;
                aw_v_d      = '0;
                w_state_d   = WWaitFs;
                beat_d      = '0;
                w_h_d       = '0;
                w_v_d       = '0;
            end
        end else begin
            if ((aw_state_q == AwRun) && aw_hs) begin
                if (aw_h_next >= width_q) begin
                    aw_h_d      = '0;
                    line_base_d = next_line_base;
                    awaddr_d    = next_line_base;
                    if ((aw_v_q + V_WIDTH'(1)) == height_q) begin
                        aw_state_d = AwDone;
                    end else begin
                        aw_v_d = aw_v_q + V_WIDTH'(1);
                    end
                end else begin
                    aw_h_d   = aw_h_next;
                    awaddr_d = awaddr_q + burst_bytes;
                end
            end

            unique case (w_state_q)
                WWaitFs: begin
                    // The start beat is left on the bus and consumed in WData.
                    if (s_axi4s_tvalid_i && s_axi4s_tuser_i[0]) begin
                        w_state_d = WData;
                    end
                end
                WData: begin
                    if (w_hs) begin
                        beat_d = m_axi4_wlast_o ? '0 : beat_q + AXI4_LEN_WIDTH'(1);
                        if (w_h_next >= width_q) begin
                            w_h_d = '0;
                            if ((w_v_q + V_WIDTH'(1)) == height_q) begin
                                w_state_d = WDone;
                            end else begin
                                w_v_d = w_v_q + V_WIDTH'(1);
                            end
                        end else begin
                            w_h_d = w_h_next;
                        end
                    end
                end
                WIdle, WDone: ;
            endcase

            if (done_all) begin
                busy_d     = 1'b0;
                aw_state_d = AwIdle;
                w_state_d  = WIdle;
            end
        end

        unique case ({aw_hs, b_hs})
            2'b10: outst_d = outst_q + OUTSTANDING_WIDTH'(1);
            2'b01: if (outst_q != '0) outst_d = outst_q - OUTSTANDING_WIDTH'(1);
            default: ;
        endcase
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            busy_q      <= 1'b0;
            index_q     <= '1;
            addr_q      <= '0;
            stride_q    <= '0;
            width_q     <= '0;
            height_q    <= '0;
            awlen_q     <= '0;
            aw_state_q  <= AwIdle;
            awaddr_q    <= '0;
            line_base_q <= '0;
            aw_h_q      <= '0;
            aw_v_q      <= '0;
            w_state_q   <= WIdle;
            beat_q      <= '0;
            w_h_q       <= '0;
            w_v_q       <= '0;
            outst_q     <= '0;
        end else begin
            busy_q      <= busy_d;
            index_q     <= index_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            width_q     <= width_d;
            height_q    <= height_d;
            awlen_q     <= awlen_d;
            aw_state_q  <= aw_state_d;
            awaddr_q    <= awaddr_d;
            line_base_q <= line_base_d;
            aw_h_q      <= aw_h_d;
            aw_v_q      <= aw_v_d;
            w_state_q   <= w_state_d;
            beat_q      <= beat_d;
            w_h_q       <= w_h_d;
            w_v_q       <= w_v_d;
            outst_q     <= outst_d;
        end
    end

endmodule

// File: tb/tb_vdma_axi4s_to_axi4_core.sv
// Directed bench for vdma_axi4s_to_axi4_core (built with a 2-bit outstanding
// counter so the limit of 3 bursts is reachable).
module tb_vdma_axi4s_to_axi4_core;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        busy;
    logic [31:0] param_addr;
    logic [11:0] param_stride, param_width, param_height;
    logic [7:0]  param_awlen;
    logic [7:0]  status_index;
    logic [31:0] status_addr;
    logic [11:0] status_stride, status_width, status_height;
    logic [7:0]  status_awlen;
    logic [5:0]  awid;
    logic [31:0] awaddr;
    logic [1:0]  awburst;
    logic [3:0]  awcache, awqos, awregion;
    logic [7:0]  awlen;
    logic        awlock;
    logic [2:0]  awprot, awsize;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [0:0]  tuser;
    logic        tlast;
    logic [23:0] tdata;
    logic        tvalid, tready;

    always #5 aclk = ~aclk;

    vdma_axi4s_to_axi4_core #(
        .OUTSTANDING_WIDTH(2)
    ) dut (
        .aresetn_i(aresetn), .aclk_i(aclk), .enable_i(enable), .busy_o(busy),
        .param_addr_i(param_addr), .param_stride_i(param_stride),
        .param_width_i(param_width), .param_height_i(param_height),
        .param_awlen_i(param_awlen),
        .status_index_o(status_index), .status_addr_o(status_addr),
        .status_stride_o(status_stride), .status_width_o(status_width),
        .status_height_o(status_height), .status_awlen_o(status_awlen),
        .m_axi4_awid_o(awid), .m_axi4_awaddr_o(awaddr), .m_axi4_awburst_o(awburst),
        .m_axi4_awcache_o(awcache), .m_axi4_awlen_o(awlen), .m_axi4_awlock_o(awlock),
        .m_axi4_awprot_o(awprot), .m_axi4_awqos_o(awqos), .m_axi4_awregion_o(awregion),
        .m_axi4_awsize_o(awsize), .m_axi4_awvalid_o(awvalid), .m_axi4_awready_i(awready),
        .m_axi4_wdata_o(wdata), .m_axi4_wstrb_o(wstrb), .m_axi4_wlast_o(wlast),
        .m_axi4_wvalid_o(wvalid), .m_axi4_wready_i(wready),
        .m_axi4_bid_i(bid), .m_axi4_bresp_i(bresp), .m_axi4_bvalid_i(bvalid),
        .m_axi4_bready_o(bready),
        .s_axi4s_tuser_i(tuser), .s_axi4s_tlast_i(tlast), .s_axi4s_tdata_i(tdata),
        .s_axi4s_tvalid_i(tvalid), .s_axi4s_tready_o(tready)
    );

    // Slave model controls (written by the main sequence only).
    logic rnd = 1'b0;
    logic aw_hold = 1'b0;
    int   b_limit = 32'h3fff_ffff;

    // Observations (written by the monitor only).
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    logic        wl_q[$];
    int          pend_b = 0;
    int          b_cnt = 0;
    int          t_acc = 0;
    int          bp_viol = 0;

    int checks = 0;
    int passes = 0;

    assign bid   = '0;
    assign bresp = 2'b00;

    // Responder: updates ready/valid just after each rising edge.
    initial begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            awready = aw_hold ? 1'b0 : (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            wready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bvalid  = (pend_b > 0) && (b_cnt < b_limit) &&
                      (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
    end

    // Monitor: handshakes are sampled mid-cycle, where all signals are settled.
    always @(negedge aclk) begin
        if (!aresetn) begin
            pend_b <= 0;
        end else begin
            if (awvalid && awready) aw_q.push_back(awaddr);
            if (wvalid && wready) begin
                w_q.push_back(wdata);
                wl_q.push_back(wlast);
            end
            if (wvalid && (tready != wready)) bp_viol <= bp_viol + 1;
            if (tvalid && tready) t_acc <= t_acc + 1;
            if (bvalid && bready) b_cnt <= b_cnt + 1;
            pend_b <= pend_b + ((awvalid && awready) ? 1 : 0) - ((bvalid && bready) ? 1 : 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic neg();
        @(negedge aclk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] a, input logic [11:0] s, input logic [11:0] w,
                               input logic [11:0] h, input logic [7:0] l);
        param_addr = a; param_stride = s; param_width = w; param_height = h; param_awlen = l;
        enable = 1'b1;
        @(posedge aclk);
        #1;
        enable = 1'b0;
    endtask

    task automatic send(input logic [23:0] d, input logic u);
        int  n;
        logic acc;
        tdata = d; tuser = u; tvalid = 1'b1; acc = 1'b0; n = 0;
        while (!acc && n < 400) begin
            @(negedge aclk);
            acc = tready;
            n++;
        end
        @(posedge aclk);
        #1;
        tvalid = 1'b0; tuser = 1'b0;
        if (!acc) chk("send_timeout", {31'b0, acc}, 32'd1);
    endtask

    task automatic send_frame(input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++) send(base + 24'(i), (i == 0));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge aclk);
            n++;
        end
        if (busy) chk(tag, {31'b0, busy}, 32'd0);
        neg();
    endtask

    int a0, w0, b0, t0;

    initial begin
        aresetn = 1'b0; enable = 1'b0;
        param_addr = '0; param_stride = '0; param_width = '0; param_height = '0;
        param_awlen = '0;
        tvalid = 1'b0; tdata = '0; tuser = '0; tlast = 1'b0;
        repeat (3) neg();

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_index", 32'(status_index), 32'hff);
        chk("rst_awvalid", 32'(awvalid), 0);
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_tready", 32'(tready), 0);
        chk("rst_bready", 32'(bready), 1);
        aresetn = 1'b1;
        repeat (2) neg();

        // Basic frame
        a0 = aw_q.size(); w0 = w_q.size(); b0 = b_cnt;
        start_frame(32'h1000, 12'd16, 12'd8, 12'd2, 8'd3);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_index", 32'(status_index), 32'h00);
        chk("t1_awsize", {29'b0, awsize}, 32'd2);
        chk("t1_awlen", 32'(awlen), 32'd3);
        send_frame(24'hA00000, 16);
        wait_idle("t1_idle_timeout");
        chk("t1_b_at_idle", 32'(b_cnt - b0), 4);
        chk("t1_aw_count", 32'(aw_q.size() - a0), 4);
        chk("t1_aw0", aw_q[a0], 32'h1000);
        chk("t1_aw1", aw_q[a0 + 1], 32'h1010);
        chk("t1_aw2", aw_q[a0 + 2], 32'h1040);
        chk("t1_aw3", aw_q[a0 + 3], 32'h1050);
        chk("t1_w_count", 32'(w_q.size() - w0), 16);
        chk("t1_wdata0", w_q[w0], 32'h00A00000);
        chk("t1_wdata15", w_q[w0 + 15], 32'h00A0000F);
        for (int i = 0; i < 16; i++) chk($sformatf("t1_wlast%0d", i), 32'(wl_q[w0 + i]),
                                         32'((i % 4) == 3));

        // Pre-frame garbage beats are discarded
        w0 = w_q.size();
        start_frame(32'h2000, 12'd16, 12'd8, 12'd2, 8'd3);
        t0 = t_acc;
        for (int i = 0; i < 5; i++) send(24'hBAD000 + 24'(i), 1'b0);
        neg();
        chk("t2_garbage_acc", 32'(t_acc - t0), 5);
        chk("t2_garbage_now", 32'(w_q.size() - w0), 0);
        send_frame(24'h000200, 16);
        wait_idle("t2_idle_timeout");
        chk("t2_w_count", 32'(w_q.size() - w0), 16);
        chk("t2_wdata_first", w_q[w0], 32'h200);
        chk("t2_wdata_last", w_q[w0 + 15], 32'h20F);
        chk("t2_index", 32'(status_index), 32'h01);

        // Backpressure, single-beat bursts
        rnd = 1'b1;
        a0 = aw_q.size(); w0 = w_q.size(); b0 = b_cnt;
        start_frame(32'h3000, 12'd8, 12'd4, 12'd3, 8'd0);
        send_frame(24'h000300, 12);
        wait_idle("t3_idle_timeout");
        rnd = 1'b0;
        chk("t3_w_count", 32'(w_q.size() - w0), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t3_wdata%0d", i), w_q[w0 + i], 32'h300 + 32'(i));
            chk($sformatf("t3_wlast%0d", i), 32'(wl_q[w0 + i]), 1);
        end
        chk("t3_bp_viol", 32'(bp_viol), 0);
        chk("t3_aw_count", 32'(aw_q.size() - a0), 12);
        chk("t3_aw_line1", aw_q[a0 + 4], 32'h3020);
        chk("t3_aw_last", aw_q[a0 + 11], 32'h304C);
        chk("t3_b_count", 32'(b_cnt - b0), 12);

        // Outstanding limit
        a0 = aw_q.size(); w0 = w_q.size(); b0 = b_cnt;
        b_limit = b_cnt;
        start_frame(32'h4000, 12'd4, 12'd4, 12'd2, 8'd0);
        repeat (10) neg();
        chk("t4_aw_at_limit", 32'(aw_q.size() - a0), 3);
        chk("t4_awvalid_low", 32'(awvalid), 0);
        aw_hold = 1'b1;
        b_limit = b0 + 1;
        repeat (5) neg();
        chk("t4_one_b", 32'(b_cnt - b0), 1);
        chk("t4_awvalid_resume", 32'(awvalid), 1);
        chk("t4_aw_stable", awaddr, 32'h400C);
        chk("t4_aw_held", 32'(aw_q.size() - a0), 3);
        aw_hold = 1'b0;
        b_limit = b0 + 2;
        repeat (6) neg();
        chk("t4_aw_after_simul", 32'(aw_q.size() - a0), 5);
        chk("t4_b_after_simul", 32'(b_cnt - b0), 2);
        chk("t4_awvalid_low2", 32'(awvalid), 0);
        b_limit = 32'h3fff_ffff;
        send_frame(24'h000400, 8);
        wait_idle("t4_idle_timeout");
        chk("t4_aw_total", 32'(aw_q.size() - a0), 8);
        chk("t4_aw_last", aw_q[a0 + 7], 32'h401C);
        chk("t4_w_count", 32'(w_q.size() - w0), 8);

        // Reset mid-frame
        start_frame(32'h5000, 12'd16, 12'd8, 12'd2, 8'd3);
        send_frame(24'h000500, 6);
        tdata = 24'h000506; tvalid = 1'b1;
        neg();
        chk("t5_wvalid_before", 32'(wvalid), 1);
        aresetn = 1'b0;
        #1;
        chk("t5_awvalid", 32'(awvalid), 0);
        chk("t5_wvalid", 32'(wvalid), 0);
        chk("t5_tready", 32'(tready), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_index", 32'(status_index), 32'hff);
        tvalid = 1'b0;
        repeat (3) neg();
        aresetn = 1'b1;
        repeat (2) neg();
        a0 = aw_q.size(); w0 = w_q.size(); b0 = b_cnt;
        start_frame(32'h6000, 12'd16, 12'd8, 12'd2, 8'd3);
        send_frame(24'h000600, 16);
        wait_idle("t5_idle_timeout");
        chk("t5_aw_count", 32'(aw_q.size() - a0), 4);
        chk("t5_aw0", aw_q[a0], 32'h6000);
        chk("t5_aw3", aw_q[a0 + 3], 32'h6050);
        chk("t5_w_count", 32'(w_q.size() - w0), 16);
        chk("t5_wlast3", 32'(wl_q[w0 + 3]), 1);
        chk("t5_b_count", 32'(b_cnt - b0), 4);
        chk("t5_index_new", 32'(status_index), 32'h00);

        // enable held high: back-to-back frames
        a0 = aw_q.size(); w0 = w_q.size();
        param_addr = 32'h7000; param_stride = 12'd4; param_width = 12'd4;
        param_height = 12'd1; param_awlen = 8'd3;
        enable = 1'b1;
        @(posedge aclk);
        #1;
        param_addr = 32'h8000;
        neg();
        chk("t6_shadow_held", status_addr, 32'h7000);
        chk("t6_index1", 32'(status_index), 32'h01);
        send_frame(24'h000700, 4);
        send_frame(24'h000800, 4);
        enable = 1'b0;
        wait_idle("t6_idle_timeout");
        chk("t6_index2", 32'(status_index), 32'h02);
        chk("t6_shadow_new", status_addr, 32'h8000);
        chk("t6_aw_count", 32'(aw_q.size() - a0), 2);
        chk("t6_aw_f1", aw_q[a0], 32'h7000);
        chk("t6_aw_f2", aw_q[a0 + 1], 32'h8000);
        chk("t6_w_count", 32'(w_q.size() - w0), 8);
        chk("t6_wdata_f2", w_q[w0 + 4], 32'h800);
        repeat (5) neg();
        chk("t6_stays_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
